// File: rtl/memp_row_packer_pkg.sv
// Shared definitions for the P-vector row packer and its neighbours:
// default geometry, state encoding and the lane-index width helper.
package memp_row_packer_pkg;

    localparam int ELEMENT_WIDTH = 64;
    localparam int NO_OF_UNITS   = 8;
    localparam int ADDRESS_WIDTH = 20;
    localparam int COUNT_WIDTH   = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } pack_state_t;

    // Width of a lane index; kept at least one bit so a single-lane row
    // still has a legal counter.
    function automatic int lane_index_width(input int units);
        return (units > 1) ? $clog2(units) : 1;
    endfunction

    localparam int LANE_WIDTH = lane_index_width(NO_OF_UNITS);
    localparam int ROW_WIDTH  = NO_OF_UNITS * ELEMENT_WIDTH;

endpackage

// File: rtl/memp_row_packer_if.sv
// Bus between the element stream source / memory write port and the row
// packer. master = the environment driving the load, slave = the packer.
interface memp_row_packer_if
    import memp_row_packer_pkg::*;
#(
    parameter int element_width = ELEMENT_WIDTH,
    parameter int no_of_units   = NO_OF_UNITS,
    parameter int address_width = ADDRESS_WIDTH,
    parameter int count_width   = COUNT_WIDTH
);
    localparam int row_width = no_of_units * element_width;

    logic                     start;
    logic [address_width-1:0] base_address;
    logic [count_width-1:0]   total_elements;
    logic [element_width-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     write_enable;
    logic [address_width-1:0] write_address;
    logic [row_width-1:0]     write_data;
    logic                     busy;
    logic                     finish;

    modport master (
        output start, base_address, total_elements, in_data, in_valid,
        input  in_ready, write_enable, write_address, write_data, busy, finish
    );

    modport slave (
        input  start, base_address, total_elements, in_data, in_valid,
        output in_ready, write_enable, write_address, write_data, busy, finish
    );

endinterface

// File: rtl/memp_row_packer.sv
// Row packer: collects no_of_units element words per row and writes each
// row to consecutive memory addresses starting at a programmable base.
// Optional build macro MEMP_PACK_ZERO_PAD_EN: clear the row register after
// every write so unfilled lanes of a partial last row are written as zero;
// without it those lanes keep the previous row's contents.
module memp_row_packer
    import memp_row_packer_pkg::*;
#(
    parameter int element_width = ELEMENT_WIDTH,
    parameter int no_of_units   = NO_OF_UNITS,
    parameter int address_width = ADDRESS_WIDTH,
    parameter int count_width   = COUNT_WIDTH
)(
    input  logic              clk,
    input  logic              reset,
    memp_row_packer_if.slave  bus
);

    localparam int row_width  = no_of_units * element_width;
    localparam int lane_width = lane_index_width(no_of_units);
    localparam logic [lane_width-1:0] lane_last = lane_width'(no_of_units - 1);

    pack_state_t              state_r;
    pack_state_t              state_next_s;
    logic [lane_width-1:0]    lane_r;
    logic [lane_width-1:0]    lane_next_s;
    logic [count_width-1:0]   remaining_r;
    logic [count_width-1:0]   remaining_next_s;
    logic [address_width-1:0] row_addr_r;
    logic [address_width-1:0] row_addr_next_s;
    logic [row_width-1:0]     row_r;
    logic [row_width-1:0]     row_ins_s;
    logic [row_width-1:0]     row_next_s;
    logic                     transfer_s;

    logic                     in_ready_r;
    logic                     write_enable_r;
    logic [address_width-1:0] write_address_r;
    logic [row_width-1:0]     write_data_r;
    logic                     busy_r;
    logic                     finish_r;

    // Next-state, counter and lane-insert logic for the load sequencer.
    always_comb begin
        state_next_s     = state_r;
        lane_next_s      = lane_r;
        remaining_next_s = remaining_r;
        row_addr_next_s  = row_addr_r;
        row_ins_s        = row_r;
        transfer_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    row_addr_next_s  = bus.base_address;
                    remaining_next_s = bus.total_elements;
                    lane_next_s      = '0;
                    if (bus.total_elements == '0) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                transfer_s = bus.in_valid && in_ready_r;
                if (transfer_s) begin
                    row_ins_s[lane_r*element_width +: element_width] = bus.in_data;
                    lane_next_s      = lane_r + lane_width'(1);
                    remaining_next_s = remaining_r - count_width'(1);
                    // Row closes when its last lane fills or the load runs out.
                    if ((lane_r == lane_last) || (remaining_r == count_width'(1))) begin
                        state_next_s = ST_WRITE;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_WRITE: begin
                // Address wraps silently at all-ones.
                row_addr_next_s = row_addr_r + address_width'(1);
                lane_next_s     = '0;
                if (remaining_r != '0) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Row register update, optionally cleared once a row has been written.
    always_comb begin
        row_next_s = row_ins_s;
`ifdef MEMP_PACK_ZERO_PAD_EN
        if (state_r == ST_WRITE) begin
            row_next_s = '0;
        end else begin
            row_next_s = row_ins_s;
        end
`endif
    end

    // State, counters, row buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            lane_r          <= '0;
            remaining_r     <= '0;
            row_addr_r      <= '0;
            row_r           <= '0;
            in_ready_r      <= 1'b0;
            write_enable_r  <= 1'b0;
            write_address_r <= '0;
            write_data_r    <= '0;
            busy_r          <= 1'b0;
            finish_r        <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            lane_r         <= lane_next_s;
            remaining_r    <= remaining_next_s;
            row_addr_r     <= row_addr_next_s;
            row_r          <= row_next_s;
            in_ready_r     <= (state_next_s == ST_FILL);
            write_enable_r <= (state_next_s == ST_WRITE);
            busy_r         <= (state_next_s != ST_IDLE);
            finish_r       <= (state_next_s == ST_DONE);
            // Present the completed row (including the element accepted on
            // this edge) for the single WRITE cycle, then hold it.
            if ((state_r == ST_FILL) && (state_next_s == ST_WRITE)) begin
                write_address_r <= row_addr_r;
                write_data_r    <= row_ins_s;
            end
        end
    end

    assign bus.in_ready      = in_ready_r;
    assign bus.write_enable  = write_enable_r;
    assign bus.write_address = write_address_r;
    assign bus.write_data    = write_data_r;
    assign bus.busy          = busy_r;
    assign bus.finish        = finish_r;

endmodule

// File: tb/tb_memp_row_packer.sv
// Randomized self-checking bench for memp_row_packer. Expected rows are
// built by chunking the element list into rows of eight and numbering them
// from the base address; timing is checked against the stated latencies.
module tb_memp_row_packer;

    localparam int EW = 64;
    localparam int NU = 8;
    localparam int AW = 20;
    localparam int CW = 20;
    localparam int RW = NU * EW;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    memp_row_packer_if bus ();

    memp_row_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] stim [$];
    logic [RW-1:0] model_row;
    logic [AW-1:0] last_wa;
    logic [RW-1:0] last_wd;

    task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, bus.in_ready, 1'b0);
        check_eq({tag, "_we"}, bus.write_enable, 1'b0);
        check_eq({tag, "_wa"}, bus.write_address, '0);
        check_eq({tag, "_wd"}, bus.write_data, '0);
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        check_eq({tag, "_finish"}, bus.finish, 1'b0);
    endtask

    // mode 0: valid always, 1: pattern 1,0,0, other: random valid
    task automatic run_load(input logic [AW-1:0] base, input int total, input int mode,
                            input bit inject, input int exp_span);
        logic [AW-1:0] exp_a [$];
        logic [RW-1:0] exp_d [$];
        logic [RW-1:0] row;
        logic [AW-1:0] a;
        int idx = 0;
        int cyc = 0;
        int first_acc = -1;
        int last_acc = -1;
        bit fin = 1'b0;
        bit prev_we = 1'b0;
        bit injected = 1'b0;
        bit v;

        for (int r = 0; r * NU < total; r++) begin
`ifdef MEMP_PACK_ZERO_PAD_EN
            row = '0;
`else
            row = model_row;
`endif
            for (int k = 0; k < NU && (r * NU + k) < total; k++)
                row[k*EW +: EW] = stim[r*NU + k];
            a = base + AW'(r);
            exp_a.push_back(a);
            exp_d.push_back(row);
            model_row = row;
        end

        @(negedge clk);
        bus.start = 1'b1;
        bus.base_address = base;
        bus.total_elements = CW'(total);
        bus.in_valid = 1'b0;

        while (!fin && cyc < 500) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;

            check_eq("in_ready_fill_only", bus.in_ready, bus.busy && !bus.write_enable && !bus.finish);
            if (bus.write_enable) begin
                if (exp_a.size() == 0) begin
                    check_eq("unexpected_write", bus.write_enable, 1'b0);
                end else begin
                    check_eq("wr_addr", bus.write_address, exp_a[0]);
                    check_eq("wr_data", bus.write_data, exp_d[0]);
                    last_wa = exp_a.pop_front();
                    last_wd = exp_d.pop_front();
                end
                check_eq("wr_latency", cyc, last_acc + 1);
                check_eq("wr_one_cycle", prev_we, 1'b0);
            end else begin
                check_eq("wa_hold", bus.write_address, last_wa);
                check_eq("wd_hold", bus.write_data, last_wd);
            end
            prev_we = bus.write_enable;

            if (bus.finish) begin
                fin = 1'b1;
                check_eq("fin_latency", cyc, (total == 0) ? 1 : last_acc + 2);
                if (exp_span > 0) check_eq("fin_span", cyc - first_acc, exp_span);
            end

            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc - 1) % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            bus.in_data  = (idx < total) ? stim[idx] : {$urandom, $urandom};
            if (v && bus.in_ready) begin
                if (idx < total) begin
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                    idx++;
                end else begin
                    check_eq("extra_accept", bus.in_ready, 1'b0);
                end
            end

            if (inject && !injected && idx == 3) begin
                bus.start = 1'b1;
                bus.base_address = 20'h00999;
                bus.total_elements = 20'd3;
                injected = 1'b1;
            end
        end

        check_eq("finish_seen", fin, 1'b1);
        check_eq("rows_written", exp_a.size(), 0);
        check_eq("all_accepted", idx, total);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        check_eq("finish_one_cycle", bus.finish, 1'b0);
        check_eq("idle_after", bus.busy, 1'b0);
    endtask

    task automatic fill_random(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back({$urandom, $urandom});
    endtask

    initial begin
        int n;
        int g;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.base_address = '0;
        bus.total_elements = '0;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        model_row = '0;
        last_wa = '0;
        last_wd = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Full rows, in_valid held high, data 1..16
        stim.delete();
        for (int i = 1; i <= 16; i++) stim.push_back(EW'(i));
        run_load(20'h00010, 16, 0, 1'b0, 18);

        // Partial last row: A0..AA
        stim.delete();
        for (int i = 0; i < 11; i++) stim.push_back(EW'(8'hA0 + i));
        run_load(20'h00000, 11, 0, 1'b0, 0);

        // Gaps in in_valid
        fill_random(13);
        run_load(20'h00040, 13, 1, 1'b0, 0);

        // Zero count
        stim.delete();
        run_load(20'h00055, 0, 0, 1'b0, 0);

        // Second start during FILL is ignored
        fill_random(10);
        run_load(20'h00080, 10, 2, 1'b1, 0);

        // Address wrap
        fill_random(16);
        run_load(20'hFFFFF, 16, 0, 1'b0, 0);

        // Reset after five accepts
        fill_random(16);
        @(negedge clk);
        bus.start = 1'b1;
        bus.base_address = 20'h00030;
        bus.total_elements = 20'd16;
        n = 0;
        g = 0;
        while (n < 5 && g < 50) begin
            @(negedge clk);
            g++;
            bus.start = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data = stim[n];
            if (bus.in_ready) n++;
        end
        check_eq("pre_reset_accepts", n, 5);
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("post_rst_we", bus.write_enable, 1'b0);
            check_eq("post_rst_finish", bus.finish, 1'b0);
            check_eq("post_rst_busy", bus.busy, 1'b0);
        end
        bus.in_valid = 1'b0;
        model_row = '0;
        last_wa = '0;
        last_wd = '0;
        fill_random(9);
        run_load(20'h00020, 9, 2, 1'b0, 0);

        // Random loads
        for (int t = 0; t < 4; t++) begin
            int tot;
            tot = $urandom_range(1, 20);
            fill_random(tot);
            run_load(AW'($urandom), tot, 2, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
